pwm_car_axi_slave: RTL

- AXI4-Lite responder (slave) for the car motor PWM peripheral, the far end of the AXI4-Lite master that exercises it.
- Holds four 32-bit read/write registers and generates two PWM motor outputs plus direction lines from them.
- Sits between the interconnect and the car's H-bridge pins.

---
 rtl/pwm_car_pkg.sv | 29 ++
 rtl/pwm_car_gen.sv | 61 ++++++
 rtl/pwm_car_axi_slave.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pwm_car_pkg.sv
// rtl/pwm_car_pkg.sv - shared register map, response codes and channel state types
package pwm_car_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_DUTY_L = 2'd2;
  localparam logic [1:0] REG_DUTY_R = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_DIR_L = 1;
  localparam int CTRL_DIR_R = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_car_gen.sv
// rtl/pwm_car_gen.sv - PWM counter, period-aligned duty shadows and registered motor outputs
module pwm_car_gen #(
  parameter int PWM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 dir_l_in,
  input  logic                 dir_r_in,
  input  logic [PWM_WIDTH-1:0] period,
  input  logic [PWM_WIDTH-1:0] duty_l,
  input  logic [PWM_WIDTH-1:0] duty_r,
  output logic                 pwm_l,
  output logic                 pwm_r,
  output logic                 dir_l,
  output logic                 dir_r
);

  localparam logic [PWM_WIDTH-1:0] ONE = PWM_WIDTH'(1);

  logic [PWM_WIDTH-1:0] cnt;
  logic [PWM_WIDTH-1:0] shadow_l;
  logic [PWM_WIDTH-1:0] shadow_r;
  logic [PWM_WIDTH-1:0] duty_l_eff;
  logic [PWM_WIDTH-1:0] duty_r_eff;
  logic                 run;

  assign run = enable && (period != '0);

  // At counter 0 the live duty is used directly so a new period starts with the new value.
  assign duty_l_eff = (cnt == '0) ? duty_l : shadow_l;
  assign duty_r_eff = (cnt == '0) ? duty_r : shadow_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      shadow_l <= '0;
      shadow_r <= '0;
      pwm_l    <= 1'b0;
      pwm_r    <= 1'b0;
      dir_l    <= 1'b0;
      dir_r    <= 1'b0;
    end else begin
      dir_l    <= dir_l_in;
      dir_r    <= dir_r_in;
      shadow_l <= duty_l_eff;
      shadow_r <= duty_r_eff;
      if (!run) begin
        cnt   <= '0;
        pwm_l <= 1'b0;
        pwm_r <= 1'b0;
      end else begin
        // >= also catches a counter stranded above a freshly shortened period.
        cnt   <= (cnt >= period - ONE) ? '0 : cnt + ONE;
        pwm_l <= (cnt < duty_l_eff);
        pwm_r <= (cnt < duty_r_eff);
      end
    end
  end

endmodule

// File: rtl/pwm_car_axi_slave.sv
// rtl/pwm_car_axi_slave.sv - AXI4-Lite register block driving the car motor PWM generator
module pwm_car_axi_slave
  import pwm_car_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PWM_WIDTH          = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            pwm_l,
  output logic                            pwm_r,
  output logic                            dir_l,
  output logic                            dir_r
);

  logic [C_S_AXI_DATA_WIDTH-1:0]   regs [4];
  wr_state_t                       wr_state, wr_next;
  rd_state_t                       rd_state, rd_next;
  logic                            aw_done, w_done;
  logic [1:0]                      wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic                            aw_hs, w_hs, ar_hs, commit;
  logic                            unused_inputs;

  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_awready = (wr_state == W_IDLE) && !aw_done;
  assign s00_axi_wready  = (wr_state == W_IDLE) && !w_done;
  assign s00_axi_bvalid  = (wr_state == W_RESP);
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_arready = (rd_state == R_IDLE);
  assign s00_axi_rvalid  = (rd_state == R_DATA);
  assign s00_axi_rresp   = RESP_OKAY;
  assign s00_axi_rdata   = rdata_q;

  assign aw_hs  = s00_axi_awvalid && s00_axi_awready;
  assign w_hs   = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid && s00_axi_arready;
  assign commit = (wr_state == W_IDLE) && aw_done && w_done;

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE: if (commit) wr_next = W_RESP;
      W_RESP: if (s00_axi_bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE: if (ar_hs) rd_next = R_DATA;
      R_DATA: if (s00_axi_rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // AW and W latch independently; the commit cycle clears both so the
  // ready lines reopen together once the B handshake leaves W_RESP.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
      wr_strb <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (aw_hs) begin
        aw_done <= 1'b1;
        wr_idx  <= s00_axi_awaddr[3:2];
      end
      if (w_hs) begin
        w_done  <= 1'b1;
        wr_data <= s00_axi_wdata;
        wr_strb <= s00_axi_wstrb;
      end
      if (commit) begin
        regs[wr_idx] <= apply_strb(regs[wr_idx], wr_data, wr_strb);
        aw_done      <= 1'b0;
        w_done       <= 1'b0;
      end
    end
  end

  // A read in the commit cycle sees the pre-write value.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      rdata_q <= '0;
    end else if (ar_hs) begin
      rdata_q <= regs[s00_axi_araddr[3:2]];
    end
  end

  pwm_car_gen #(
    .PWM_WIDTH (PWM_WIDTH)
  ) u_gen (
    .clk      (s00_axi_aclk),
    .reset    (s00_axi_areset),
    .enable   (regs[REG_CTRL][CTRL_EN]),
    .dir_l_in (regs[REG_CTRL][CTRL_DIR_L]),
    .dir_r_in (regs[REG_CTRL][CTRL_DIR_R]),
    .period   (regs[REG_PERIOD][PWM_WIDTH-1:0]),
    .duty_l   (regs[REG_DUTY_L][PWM_WIDTH-1:0]),
    .duty_r   (regs[REG_DUTY_R][PWM_WIDTH-1:0]),
    .pwm_l    (pwm_l),
    .pwm_r    (pwm_r),
    .dir_l    (dir_l),
    .dir_r    (dir_r)
  );

endmodule
